// File: rtl/irq_ctrl_if.sv
// Register-window and CPU interrupt handshake bundle for irq_ctrl.
interface irq_ctrl_if;
  logic [2:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;
  logic [2:0]  vec;
  logic        ack;

  // CPU / Bridge side
  modport master (output addr, we, din, ack, input dout, irq, vec);
  // Controller side
  modport slave  (input addr, we, din, ack, output dout, irq, vec);
endinterface

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: per-source edge/level capture, masking,
// fixed-priority selection (source 0 highest) and req/ack/EOI handshake.
module irq_ctrl #(
  parameter int unsigned N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  irq_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERV} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] pend, mask, mode, src_prev;
  logic [N_SRC-1:0] pend_d, elig, vec_oh, clr, edge_set;
  logic [2:0]       vec_q, vec_d, win;
  logic             irq_q, any_elig, vec_elig, ack_take;
  logic             wr_mask, wr_mode, wr_clr, wr_eoi;
  logic             unused_din;

  assign wr_mask = bus.we && (bus.addr == 3'd1);
  assign wr_mode = bus.we && (bus.addr == 3'd2);
  assign wr_clr  = bus.we && (bus.addr == 3'd3);
  assign wr_eoi  = bus.we && (bus.addr == 3'd5);

  // Upper write-data bits have no storage behind them.
  assign unused_din = ^bus.din;

  assign bus.irq = irq_q;
  assign bus.vec = vec_q;

  // Eligible set, priority winner, and whether the latched vector is still eligible.
  always_comb begin
    elig     = pend & mask;
    win      = '0;
    any_elig = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (elig[i] && !any_elig) begin
        win      = 3'(i);
        any_elig = 1'b1;
      end
    end
    vec_oh = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      vec_oh[i] = (vec_q == 3'(i));
    end
    vec_elig = |(elig & vec_oh);
  end

  // Handshake next-state: no preemption while in REQ, ack beats loss of eligibility.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    ack_take = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_elig) begin
          state_d = S_REQ;
          vec_d   = win;
        end
      end
      S_REQ: begin
        if (bus.ack) begin
          state_d  = S_SERV;
          ack_take = 1'b1;
        end else if (!vec_elig) begin
          state_d = S_IDLE;
        end
      end
      S_SERV: begin
        if (wr_eoi) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending capture: edge bits set-dominant over CLR/ack, level bits follow src.
  always_comb begin
    clr      = (wr_clr ? bus.din[N_SRC-1:0] : '0) | (ack_take ? vec_oh : '0);
    edge_set = src & ~src_prev;
    pend_d   = (mode & ((pend & ~clr) | edge_set)) | (~mode & src);
  end

  // Handshake state and registered CPU outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      irq_q   <= (state_d == S_REQ);
    end
  end

  // Source history, pending bits and software-programmed registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      mask     <= '0;
      mode     <= '0;
      src_prev <= '0;
    end else begin
      src_prev <= src;
      pend     <= pend_d;
      if (wr_mask) mask <= bus.din[N_SRC-1:0];
      if (wr_mode) mode <= bus.din[N_SRC-1:0];
    end
  end

  // Read mux reflects pre-edge register contents.
  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      3'd0:    bus.dout = 32'(pend);
      3'd1:    bus.dout = 32'(mask);
      3'd2:    bus.dout = 32'(mode);
      3'd4:    bus.dout = {(state_q == S_SERV), 28'd0, vec_q};
      default: bus.dout = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl.
module tb_irq_ctrl;
  logic       clk;
  logic       reset;
  logic [5:0] src;
  int         n_tests;
  int         n_fail;

  irq_ctrl_if bus ();

  irq_ctrl #(.N_SRC(6)) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.din  = d;
    bus.we   = 1'b1;
    tick();
    bus.we   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(tag, bus.dout, exp);
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b0;
    src      = '0;
    bus.addr = '0;
    bus.din  = '0;
    bus.we   = 1'b0;
    bus.ack  = 1'b0;
    tick();
    tick();
    check("rst_irq", 32'(bus.irq), 32'd0);
    check("rst_vec", 32'(bus.vec), 32'd0);
    rd("rst_pend", 3'd0, 32'h0);
    rd("rst_mask", 3'd1, 32'h0);
    rd("rst_mode", 3'd2, 32'h0);
    rd("rst_cur",  3'd4, 32'h0);
    reset = 1'b1;
    tick();

    // Edge latency
    wr(3'd1, 32'h3F);
    wr(3'd2, 32'h01);
    rd("mask_rb", 3'd1, 32'h3F);
    rd("off6_rd", 3'd6, 32'h0);
    src = 6'h01;
    tick();
    src = 6'h00;
    rd("edge_pend", 3'd0, 32'h01);
    check("edge_irq_early", 32'(bus.irq), 32'd0);
    tick();
    check("edge_irq", 32'(bus.irq), 32'd1);
    check("edge_vec", 32'(bus.vec), 32'd0);
    do_ack();
    check("edge_ack_irq", 32'(bus.irq), 32'd0);
    rd("edge_ack_pend", 3'd0, 32'h0);
    rd("edge_ack_cur",  3'd4, 32'h80000000);
    wr(3'd5, 32'h0);
    rd("edge_eoi_cur", 3'd4, 32'h0);
    tick();
    check("edge_eoi_irq", 32'(bus.irq), 32'd0);

    // Priority, level mode
    wr(3'd2, 32'h00);
    src = 6'b000110;
    tick();
    tick();
    check("prio_irq", 32'(bus.irq), 32'd1);
    check("prio_vec", 32'(bus.vec), 32'd1);
    do_ack();
    check("prio_ack_irq", 32'(bus.irq), 32'd0);
    src = 6'b000100;
    wr(3'd5, 32'h0);
    tick();
    check("prio2_irq", 32'(bus.irq), 32'd1);
    check("prio2_vec", 32'(bus.vec), 32'd2);

    // No preemption
    src = 6'b000101;
    tick();
    tick();
    check("npre_vec", 32'(bus.vec), 32'd2);
    check("npre_irq", 32'(bus.irq), 32'd1);
    do_ack();
    rd("npre_cur", 3'd4, 32'h80000002);
    wr(3'd5, 32'h0);
    tick();
    check("npre_next_irq", 32'(bus.irq), 32'd1);
    check("npre_next_vec", 32'(bus.vec), 32'd0);
    src = 6'b000000;
    tick();
    tick();
    check("level_drop_irq", 32'(bus.irq), 32'd0);

    // Retract by mask
    src = 6'b001000;
    tick();
    tick();
    check("ret_irq", 32'(bus.irq), 32'd1);
    check("ret_vec", 32'(bus.vec), 32'd3);
    wr(3'd1, 32'h00);
    tick();
    check("ret_irq_off", 32'(bus.irq), 32'd0);
    rd("ret_cur", 3'd4, 32'h00000003);
    wr(3'd1, 32'h3F);
    tick();
    check("ret2_irq", 32'(bus.irq), 32'd1);
    bus.ack = 1'b1;
    wr(3'd1, 32'h00);
    bus.ack = 1'b0;
    check("ackwin_irq", 32'(bus.irq), 32'd0);
    rd("ackwin_cur", 3'd4, 32'h80000003);
    wr(3'd5, 32'h0);
    tick();
    check("ackwin_eoi_irq", 32'(bus.irq), 32'd0);
    src = 6'b000000;
    tick();

    // Set/clear collision on edge source 4
    wr(3'd2, 32'h10);
    src      = 6'b010000;
    bus.addr = 3'd3;
    bus.din  = 32'h10;
    bus.we   = 1'b1;
    tick();
    bus.we   = 1'b0;
    src      = 6'b000000;
    rd("coll_pend", 3'd0, 32'h10);
    wr(3'd3, 32'h10);
    rd("clr_pend", 3'd0, 32'h00);

    // Reset mid-REQ
    wr(3'd1, 32'h10);
    src = 6'b010000;
    tick();
    src = 6'b000000;
    tick();
    check("pre_rst_irq", 32'(bus.irq), 32'd1);
    check("pre_rst_vec", 32'(bus.vec), 32'd4);
    reset = 1'b0;
    #1;
    check("mid_rst_irq", 32'(bus.irq), 32'd0);
    check("mid_rst_vec", 32'(bus.vec), 32'd0);
    rd("mid_rst_pend", 3'd0, 32'h0);
    rd("mid_rst_mask", 3'd1, 32'h0);
    rd("mid_rst_mode", 3'd2, 32'h0);
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
